// File: rtl/result_packer.sv
// Serialises a packet of WORD_W-bit result words into a byte stream: header, length,
// little-endian data bytes and (with RESULT_PACKER_CHECKSUM_EN defined) an XOR trailer.
module result_packer #(
    parameter int unsigned WORD_W   = 32,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic [7:0]        out_byte,
    output logic              out_set,
    input  logic              out_full,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      BYTES    = WORD_W / 8;
    localparam int unsigned      IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_LOAD,
        S_DATA
`ifdef RESULT_PACKER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic              done_q, done_d;
`ifdef RESULT_PACKER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic [7:0] word_bytes [BYTES];
    logic [7:0] data_byte;
    logic       emitting;
    logic [7:0] byte_mux;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_word_bytes
        assign word_bytes[gi] = word_q[gi*8 +: 8];
    end

    assign data_byte = word_bytes[byte_idx_q];

    always_comb begin
        emitting = 1'b0;
        byte_mux = 8'h00;
        case (state_q)
            S_HDR: begin
                emitting = 1'b1;
                byte_mux = HDR_BYTE;
            end
            S_LEN: begin
                emitting = 1'b1;
                byte_mux = len_q;
            end
            S_DATA: begin
                emitting = 1'b1;
                byte_mux = data_byte;
            end
`ifdef RESULT_PACKER_CHECKSUM_EN
            S_CSUM: begin
                emitting = 1'b1;
                byte_mux = csum_q;
            end
`endif
            default: begin
                emitting = 1'b0;
                byte_mux = 8'h00;
            end
        endcase
    end

    // A byte is consumed exactly when the strobe is up; that is the only advance condition.
    assign out_set    = emitting & ~out_full;
    assign out_byte   = byte_mux;
    assign word_ready = (state_q == S_LOAD);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        done_d      = 1'b0;
`ifdef RESULT_PACKER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d       = len;
                    remaining_d = len;
`ifdef RESULT_PACKER_CHECKSUM_EN
                    csum_d      = len;
`endif
                    state_d     = S_HDR;
                end
            end
            S_HDR: begin
                if (out_set) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (out_set) begin
                    if (remaining_q != 8'd0) begin
                        state_d = S_LOAD;
                    end else begin
`ifdef RESULT_PACKER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    word_d      = word_in;
                    byte_idx_d  = '0;
                    remaining_d = remaining_q - 8'd1;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (out_set) begin
`ifdef RESULT_PACKER_CHECKSUM_EN
                    csum_d = csum_q ^ data_byte;
`endif
                    if (byte_idx_q == LAST_IDX) begin
                        if (remaining_q != 8'd0) begin
                            state_d = S_LOAD;
                        end else begin
`ifdef RESULT_PACKER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_IDLE;
                            done_d  = 1'b1;
`endif
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef RESULT_PACKER_CHECKSUM_EN
            S_CSUM: begin
                if (out_set) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            len_q       <= 8'h00;
            remaining_q <= 8'h00;
            word_q      <= '0;
            byte_idx_q  <= '0;
            done_q      <= 1'b0;
`ifdef RESULT_PACKER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            done_q      <= done_d;
`ifdef RESULT_PACKER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_result_packer.sv
// Randomised bench for result_packer: a packet-level byte model is compared against the
// accepted output stream, with handshake, done and reset behaviour checked cycle by cycle.
`timescale 1ns/1ps
module tb_result_packer;

    localparam int         WORD_W = 32;
    localparam int         BYTES  = WORD_W / 8;
    localparam logic [7:0] HDR    = 8'hA5;
`ifdef RESULT_PACKER_CHECKSUM_EN
    localparam int         CS     = 1;
`else
    localparam int         CS     = 0;
`endif

    logic              clk        = 1'b0;
    logic              rst        = 1'b0;
    logic              start      = 1'b0;
    logic [7:0]        len        = 8'h00;
    logic [WORD_W-1:0] word_in    = '0;
    logic              word_valid = 1'b0;
    logic              word_ready;
    logic [7:0]        out_byte;
    logic              out_set;
    logic              out_full   = 1'b0;
    logic              busy;
    logic              done;

    int         checks       = 0;
    int         failures     = 0;
    bit         pending_done = 1'b0;
    logic [7:0] got_q [$];

    result_packer #(.WORD_W(WORD_W), .HDR_BYTE(HDR)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .out_byte   (out_byte),
        .out_set    (out_set),
        .out_full   (out_full),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Cycles from the start-driving cycle through the final accept when never stalled.
    function automatic int exp_cycles(input int n);
        return 1 + 2 + n * (1 + BYTES) + CS;
    endfunction

    task automatic run_packet(input int n, input int full_pct, input int valid_pct,
                              input bit noise, input bit use_first,
                              input logic [WORD_W-1:0] first_word,
                              input int full_from, input int full_len,
                              input int valid_from, input int valid_len,
                              output int cycles);
        logic [WORD_W-1:0] words [$];
        logic [7:0]        exp_b [$];
        logic [7:0]        c;
        logic [7:0]        v;
        int                widx;
        int                bidx;
        int                cyc;
        bit                finished;
        bit                need_word;
        bit                exp_ready;
        bit                exp_set;
        logic [7:0]        exp_out;
        widx = 0;
        bidx = 0;
        cyc = 0;
        finished = 1'b0;
        for (int i = 0; i < n; i++) begin
            words.push_back((i == 0 && use_first) ? first_word : WORD_W'($urandom));
        end
        exp_b.push_back(HDR);
        exp_b.push_back(8'(n));
        c = 8'(n);
        foreach (words[k]) begin
            for (int b = 0; b < BYTES; b++) begin
                v = 8'(words[k] >> (8 * b));
                exp_b.push_back(v);
                c = c ^ v;
            end
        end
        if (CS == 1) exp_b.push_back(c);
        got_q.delete();

        while (!finished) begin
            @(posedge clk); #1;
            start      = (cyc == 0) ? 1'b1 : (noise ? 1'($urandom_range(1)) : 1'b0);
            len        = (cyc == 0) ? 8'(n) : 8'($urandom);
            out_full   = ($urandom_range(99) < full_pct) ||
                         (cyc >= full_from && cyc < full_from + full_len);
            word_valid = (widx < n) && ($urandom_range(99) < valid_pct) &&
                         !(cyc >= valid_from && cyc < valid_from + valid_len);
            word_in    = (widx < n) ? words[widx] : WORD_W'($urandom);
            @(negedge clk);

            checks++;
            if (done !== ((cyc == 0) ? pending_done : 1'b0)) begin
                failures++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 0) ? pending_done : 1'b0);
            end
            if (cyc == 0) pending_done = 1'b0;

            checks++;
            if (busy !== (cyc != 0)) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, cyc != 0);
            end

            // The next byte due is the first byte of a word not yet fetched -> waiting for a word.
            need_word = (bidx >= 2) && (bidx < 2 + n * BYTES) &&
                        ((bidx - 2) % BYTES == 0) && (widx == (bidx - 2) / BYTES);
            exp_ready = (cyc != 0) && need_word;
            exp_set   = (cyc != 0) && !need_word && !out_full;
            exp_out   = ((cyc != 0) && !need_word) ? exp_b[bidx] : 8'h00;

            checks++;
            if (word_ready !== exp_ready) begin
                failures++;
                $display("FAIL word_ready cyc=%0d got=%b exp=%b", cyc, word_ready, exp_ready);
            end
            checks++;
            if (out_set !== exp_set) begin
                failures++;
                $display("FAIL out_set cyc=%0d got=%b exp=%b", cyc, out_set, exp_set);
            end
            checks++;
            if (out_byte !== exp_out) begin
                failures++;
                $display("FAIL out_byte cyc=%0d idx=%0d got=%02h exp=%02h", cyc, bidx, out_byte, exp_out);
            end

            if (out_set === 1'b1 && !out_full) begin
                got_q.push_back(out_byte);
                bidx++;
                if (bidx == exp_b.size()) begin
                    finished     = 1'b1;
                    pending_done = 1'b1;
                end
            end
            if (word_ready === 1'b1 && word_valid) widx++;
            cyc++;
            if (!finished && cyc > 20000) begin
                failures++;
                $display("FAIL timeout len=%0d got_bytes=%0d exp_bytes=%0d", n, bidx, exp_b.size());
                finished = 1'b1;
            end
        end
        checks++;
        if (bidx != exp_b.size() || widx != n) begin
            failures++;
            $display("FAIL stream_len got_bytes=%0d exp_bytes=%0d words=%0d exp_words=%0d",
                     bidx, exp_b.size(), widx, n);
        end
        cycles = cyc;
        $display("packet len=%0d bytes=%0d cycles=%0d", n, bidx, cyc);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            start      = 1'b0;
            out_full   = 1'($urandom_range(1));
            word_valid = 1'($urandom_range(1));
            word_in    = WORD_W'($urandom);
            @(negedge clk);
            checks++;
            if (done !== pending_done) begin
                failures++;
                $display("FAIL idle_done got=%b exp=%b", done, pending_done);
            end
            pending_done = 1'b0;
            checks++;
            if ({busy, out_set, word_ready, out_byte} !== 11'd0) begin
                failures++;
                $display("FAIL idle_outputs busy=%b out_set=%b word_ready=%b out_byte=%02h exp all 0",
                         busy, out_set, word_ready, out_byte);
            end
        end
    endtask

    task automatic check_bytes(input string name, input logic [7:0] ref_q [$]);
        checks++;
        if (got_q.size() != ref_q.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), ref_q.size());
        end else begin
            foreach (ref_q[i]) begin
                checks++;
                if (got_q[i] !== ref_q[i]) begin
                    failures++;
                    $display("FAIL %s_byte%0d got=%02h exp=%02h", name, i, got_q[i], ref_q[i]);
                end
            end
        end
    endtask

    task automatic check_cycles(input string name, input int got, input int exp_c);
        checks++;
        if (got != exp_c) begin
            failures++;
            $display("FAIL %s_cycles got=%0d exp=%0d", name, got, exp_c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        out_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, out_set, word_ready, done, out_byte} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b out_set=%b word_ready=%b done=%b out_byte=%02h exp all 0",
                     busy, out_set, word_ready, done, out_byte);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycles(3);
    endtask

    task automatic test_vector_len1();
        logic [7:0] ref_q [$];
        int cyc;
        run_packet(1, 0, 100, 1'b0, 1'b1, 32'h11223344, -1, 0, -1, 0, cyc);
        ref_q = '{8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11};
        if (CS == 1) ref_q.push_back(8'h45);
        check_bytes("vec_len1", ref_q);
        check_cycles("vec_len1", cyc, exp_cycles(1));
        idle_cycles(2);
    endtask

    task automatic test_len0();
        logic [7:0] ref_q [$];
        int cyc;
        run_packet(0, 0, 100, 1'b0, 1'b0, '0, -1, 0, -1, 0, cyc);
        ref_q = '{8'hA5, 8'h00};
        if (CS == 1) ref_q.push_back(8'h00);
        check_bytes("len0", ref_q);
        check_cycles("len0", cyc, exp_cycles(0));
        idle_cycles(2);
    endtask

    task automatic test_backpressure();
        int cyc;
        // DATA of the first word occupies cycles 4..7; hold the FIFO full across 5..9.
        run_packet(2, 0, 100, 1'b0, 1'b0, '0, 5, 5, -1, 0, cyc);
        check_cycles("full_hold", cyc, exp_cycles(2) + 5);
        idle_cycles(1);
        for (int i = 0; i < 3; i++) begin
            run_packet($urandom_range(1, 5), 50, 100, 1'b0, 1'b0, '0, -1, 0, -1, 0, cyc);
            idle_cycles(1);
        end
    endtask

    task automatic test_load_stall();
        int cyc;
        run_packet(2, 0, 100, 1'b0, 1'b0, '0, -1, 0, 3, 10, cyc);
        check_cycles("valid_hold", cyc, exp_cycles(2) + 10);
        idle_cycles(1);
        for (int i = 0; i < 3; i++) begin
            run_packet($urandom_range(1, 5), 20, 30, 1'b0, 1'b0, '0, -1, 0, -1, 0, cyc);
            idle_cycles(1);
        end
    endtask

    task automatic test_start_busy();
        int cyc;
        for (int i = 0; i < 4; i++) begin
            run_packet($urandom_range(0, 4), 25, 70, 1'b1, 1'b0, '0, -1, 0, -1, 0, cyc);
            idle_cycles(1);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(0, 5);
            run_packet(n, 0, 100, 1'b0, 1'b0, '0, -1, 0, -1, 0, cyc);
            check_cycles("b2b", cyc, exp_cycles(n));
        end
        for (int i = 0; i < 4; i++) begin
            run_packet($urandom_range(0, 6), 30, 60, 1'b1, 1'b0, '0, -1, 0, -1, 0, cyc);
        end
        run_packet(255, 20, 80, 1'b0, 1'b0, '0, -1, 0, -1, 0, cyc);
        idle_cycles(2);
    endtask

    task automatic test_reset_mid();
        logic [WORD_W-1:0] w;
        w = WORD_W'($urandom);
        @(posedge clk); #1;
        start = 1'b1; len = 8'd3; out_full = 1'b0; word_valid = 1'b1; word_in = w;
        repeat (4) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (out_set !== 1'b1 || out_byte !== w[7:0]) begin
            failures++;
            $display("FAIL mid_data out_set=%b out_byte=%02h exp 1 %02h", out_set, out_byte, w[7:0]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, out_set, word_ready, done, out_byte} !== 12'd0) begin
            failures++;
            $display("FAIL async_reset busy=%b out_set=%b word_ready=%b done=%b out_byte=%02h exp all 0",
                     busy, out_set, word_ready, done, out_byte);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        pending_done = 1'b0;
        idle_cycles(8);
        $display("reset_mid word=%08h", w);
    endtask

    initial begin
        test_reset();
        test_vector_len1();
        test_len0();
        test_backpressure();
        test_load_stall();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_vector_len1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, result word width in bits; must be a multiple of 8 and at least 8.
REQ-002 SHALL have parameter HDR_BYTE, default 8'hA5, packet start marker.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to emit one packet; sampled only in IDLE.
REQ-006 SHALL have port len  input  8  word count of the packet, latched on accepted start; 0 legal.
REQ-007 SHALL have port word_in  input  WORD_W  result word from the vector datapath.
REQ-008 SHALL have port word_valid  input  1  word_in is valid.
REQ-009 SHALL have port word_ready  output  1  packer takes word_in this cycle if word_valid.
REQ-010 SHALL have port out_byte  output  8  byte to the output FIFO/UART stage.
REQ-011 SHALL have port out_set  output  1  write strobe to the output FIFO.
REQ-012 SHALL have port out_full  input  1  output FIFO full; a byte is accepted only when out_set=1 and out_full=0.
REQ-013 SHALL have port busy  output  1  packet in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at packet end.

Function
REQ-015 SHALL implement FSM states IDLE, HDR, LEN, LOAD, DATA, CSUM.
REQ-016 IDLE: start=1 SHALL latch len into remaining-word counter and checksum register (csum<=len), then go to HDR next cycle.
REQ-017 Emitting states (HDR, LEN, DATA, CSUM) SHALL drive out_set = !out_full combinationally; out_set SHALL be 0 in IDLE and LOAD.
REQ-018 out_byte SHALL be HDR_BYTE in HDR, latched len in LEN, current data byte in DATA, csum in CSUM; 0 otherwise; held stable while out_full=1.
REQ-019 A state SHALL advance only on a cycle in which its byte is accepted; no byte is ever dropped or duplicated under back-pressure.
REQ-020 LEN accepted: remaining>0 -> LOAD; remaining=0 -> CSUM (or IDLE when checksum compiled out).
REQ-021 LOAD SHALL assert word_ready=1 and wait indefinitely; on word_valid=1 latch word_in, clear byte index, decrement remaining, go to DATA; word_ready=0 in all other states.
REQ-022 DATA SHALL emit the word little-endian, byte 0 = bits [7:0], WORD_W/8 bytes per word; each accepted byte XORs into csum.
REQ-023 DATA, last byte accepted: remaining>0 -> LOAD; remaining=0 -> CSUM (or IDLE when checksum compiled out).
REQ-024 CSUM accepted SHALL go to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored with no effect.
REQ-026 done SHALL be registered, high for exactly one cycle, the cycle after the final byte of a packet is accepted.
REQ-027 A new start SHALL be accepted in the same cycle done is high; back-to-back packets carry no idle byte gap beyond that cycle.
REQ-028 Packet length in bytes SHALL be 2 + len*WORD_W/8 + 1 (checksum enabled).

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE; counters, byte index, csum and latched word to 0; out_set, word_ready, busy, done, out_byte to 0.
REQ-030 Reset mid-packet SHALL abandon the packet; no further bytes emitted after release until a new start.

Configuration
REQ-031 Macro RESULT_PACKER_CHECKSUM_EN defined: CSUM state present, trailer byte = XOR of len and all data bytes (header excluded).
REQ-032 Macro undefined: CSUM state and csum register absent; packet ends after last data byte (or after LEN when len=0); length 2 + len*WORD_W/8.

Verification
REQ-033 WORD_W=32, checksum on, len=1, word 0x11223344, out_full=0 -> bytes A5,01,44,33,22,11,45 on consecutive accepts; done one cycle after 45.
REQ-034 len=0 -> A5,00,00; word_ready never asserted; done after third byte.
REQ-035 len=2, out_full held 1 for 5 cycles mid-DATA -> out_set=0 for those cycles, out_byte stable, full 11-byte stream intact and in order.
REQ-036 word_valid withheld 10 cycles in LOAD -> word_ready=1 throughout, out_set=0, stream resumes correctly.
REQ-037 start pulsed while busy -> ignored; rst=0 mid-DATA -> all outputs 0 immediately, IDLE after release.
REQ-038 Checksum compiled out, len=1, word 0x11223344 -> A5,01,44,33,22,11 only; done after 11.
